// File: rtl/rcv_control.sv
// Receive-side sequencer for the USB NRZI decoder: bit timing, destuffing, SYNC check, byte output.
// Optional STUFF_CHECK_EN: a stuffed-bit slot carrying a 1 is treated as a framing error.
module rcv_control #(
    parameter int         CLKS_PER_BIT = 8,
    parameter int         SAMPLE_PHASE = 3,
    parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       d_orig,
    output logic       shift_enable,
    output logic [7:0] rcv_data,
    output logic       w_enable,
    output logic       rcving,
    output logic       r_error
);
    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_PHASE);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SYNC       = 3'd1,
        CHECK_SYNC = 3'd2,
        RECEIVE    = 3'd3,
        STORE      = 3'd4,
        ERR_WAIT   = 3'd5,
        EOP_WAIT   = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic [2:0]    ones;
    logic [7:0]    shreg;
    logic [7:0]    shifted;
    logic          stuff_bad;

    assign shift_enable = (state != IDLE) && (cnt == CNT_SAMPLE);
    assign shifted      = {d_orig, shreg[7:1]};

`ifdef STUFF_CHECK_EN
    assign stuff_bad = d_orig;
`else
    assign stuff_bad = 1'b0;
`endif

    // Bit timer: free-running per bit, resynchronised by every line transition
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == IDLE) || d_edge) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Packet sequencer; rcv_data is loaded together with w_enable so the FIFO sees both at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bitcnt   <= 4'd0;
            ones     <= 3'd0;
            shreg    <= 8'h00;
            rcv_data <= 8'h00;
            w_enable <= 1'b0;
            rcving   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            w_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_edge) begin
                        state   <= SYNC;
                        rcving  <= 1'b1;
                        r_error <= 1'b0;
                        bitcnt  <= 4'd0;
                        ones    <= 3'd0;
                    end
                end
                SYNC, RECEIVE: begin
                    if (shift_enable) begin
                        if (eop) begin
                            // eop outranks both a stuffed slot and an 8th-bit acceptance
                            if ((state == RECEIVE) && (bitcnt == 4'd0)) begin
                                state <= EOP_WAIT;
                            end else begin
                                state   <= ERR_WAIT;
                                r_error <= 1'b1;
                            end
                        end else if (ones == 3'd6) begin
                            ones <= 3'd0;
                            if (stuff_bad) begin
                                state   <= ERR_WAIT;
                                r_error <= 1'b1;
                            end
                        end else begin
                            shreg  <= shifted;
                            bitcnt <= (bitcnt >= 4'd8) ? 4'd8 : bitcnt + 4'd1;
                            ones   <= d_orig ? ones + 3'd1 : 3'd0;
                            if (bitcnt == 4'd7) begin
                                if (state == SYNC) begin
                                    state <= CHECK_SYNC;
                                end else begin
                                    state    <= STORE;
                                    rcv_data <= shifted;
                                    w_enable <= 1'b1;
                                end
                            end
                        end
                    end
                end
                CHECK_SYNC: begin
                    if (shreg == SYNC_BYTE) begin
                        state  <= RECEIVE;
                        bitcnt <= 4'd0;
                    end else begin
                        state   <= ERR_WAIT;
                        r_error <= 1'b1;
                    end
                end
                STORE: begin
                    bitcnt <= 4'd0;
                    state  <= RECEIVE;
                end
                ERR_WAIT: begin
                    if (shift_enable && eop) begin
                        state <= EOP_WAIT;
                    end
                end
                EOP_WAIT: begin
                    if (d_edge) begin
                        state  <= IDLE;
                        rcving <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rcving <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rcv_control.sv
// Self-checking bench for rcv_control: directed scenarios plus randomized packets
// checked against a bit-level packet model (destuff, SYNC compare, byte split).
module tb_rcv_control;
    localparam int         CPB  = 8;
    localparam int         SP   = 3;
    localparam logic [7:0] SYNC = 8'h80;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_edge;
    logic       eop;
    logic       d_orig;
    logic       shift_enable;
    logic [7:0] rcv_data;
    logic       w_enable;
    logic       rcving;
    logic       r_error;

    rcv_control #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(SP), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .d_orig(d_orig),
        .shift_enable(shift_enable), .rcv_data(rcv_data), .w_enable(w_enable),
        .rcving(rcving), .r_error(r_error)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    int         se_cnt;
    int         se_bad;
    logic [7:0] wr_q[$];
    logic       rcving_lead;
    logic       err_lead;
    int         sym_q[$];     // 0/1 line bits, 2 = SE0
    int         stuff_pos[$];
    logic [7:0] byte_q[$];
    logic [7:0] exp_q[$];
    logic       exp_err;

    // One clock of stimulus; DUT outputs observed on the falling edge before new inputs are applied
    task automatic step(input int ph, input logic e, input logic o, input logic ep);
        @(negedge clk);
        if (shift_enable === 1'b1) begin
            se_cnt++;
            if (ph != SP + 1) se_bad++;
        end
        if (w_enable === 1'b1) wr_q.push_back(rcv_data);
        d_edge = e;
        d_orig = o;
        eop    = ep;
    endtask

    task automatic send_syms(input bit close);
        int   prev;
        logic e;
        se_cnt = 0; se_bad = 0; wr_q.delete(); prev = 1;
        foreach (sym_q[i]) begin
            e = (i == 0) || (sym_q[i] == 0) || ((sym_q[i] == 2) && (prev != 2));
            for (int c = 0; c < CPB; c++) begin
                step(c, (c == 0) ? e : 1'b0, (sym_q[i] == 1), (sym_q[i] == 2));
                if ((i == 0) && (c == 1)) begin
                    rcving_lead = rcving;
                    err_lead    = r_error;
                end
            end
            prev = sym_q[i];
        end
        if (close) begin
            for (int c = 0; c < CPB; c++) step(c, (c == 0), 1'b1, 1'b0);
            for (int c = 0; c < 2 * CPB; c++) step(-1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    // USB bit stream: SYNC then bytes LSB-first, a 0 stuffed after six 1s, then SE0 SE0
    task automatic encode(input logic [7:0] sync_b);
        int         ones;
        logic [7:0] b;
        sym_q.delete(); stuff_pos.delete(); ones = 0;
        for (int k = 0; k <= byte_q.size(); k++) begin
            if (k == 0) b = sync_b;
            else        b = byte_q[k-1];
            for (int j = 0; j < 8; j++) begin
                sym_q.push_back(b[j] ? 1 : 0);
                ones = b[j] ? ones + 1 : 0;
                if (ones == 6) begin
                    stuff_pos.push_back(sym_q.size());
                    sym_q.push_back(0);
                    ones = 0;
                end
            end
        end
        sym_q.push_back(2);
        sym_q.push_back(2);
    endtask

    // Expected bytes and error flag for the current symbol stream
    task automatic model();
        int         ones, nb, s;
        logic [7:0] acc;
        bit         synced, done;
        exp_q.delete(); exp_err = 1'b0;
        ones = 0; nb = 0; acc = 8'h00; synced = 0; done = 0;
        foreach (sym_q[i]) begin
            s = sym_q[i];
            if (done) begin
            end else if (s == 2) begin
                if (!exp_err && (!synced || (nb != 0))) exp_err = 1'b1;
                done = 1;
            end else if (exp_err) begin
            end else if (ones == 6) begin
                ones = 0;
`ifdef STUFF_CHECK_EN
                if (s == 1) exp_err = 1'b1;
`endif
            end else begin
                acc[nb] = s[0];
                nb++;
                ones = (s == 1) ? ones + 1 : 0;
                if (nb == 8) begin
                    if (!synced) begin
                        if (acc != SYNC) exp_err = 1'b1;
                        else             synced = 1;
                    end else begin
                        exp_q.push_back(acc);
                    end
                    nb = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; d_edge = 1'b0; eop = 1'b0; d_orig = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({rcving, w_enable, r_error, rcv_data, shift_enable} !== 12'h000) begin
                $display("FAIL reset_outputs[%0d]: got %h expected 000", i,
                         {rcving, w_enable, r_error, rcv_data, shift_enable});
            end else passes++;
            d_edge = ~d_edge;
        end
        rst = 1'b0; d_edge = 1'b0;
        @(negedge clk);
        checks++;
        if ({rcving, shift_enable} !== 2'b00) begin
            $display("FAIL reset_dominates_edge: got %b expected 00", {rcving, shift_enable});
        end else passes++;
    endtask

    task automatic test_good_packet();
        logic [7:0] got;
        byte_q.delete(); byte_q.push_back(8'hA5);
        encode(SYNC);
        send_syms(1'b1);
        got = (wr_q.size() > 0) ? wr_q[0] : 8'hxx;
        checks++; if (rcving_lead !== 1'b1) $display("FAIL good_rcving_lead: got %b expected 1", rcving_lead); else passes++;
        checks++; if (se_cnt != 18) $display("FAIL good_se_count: got %0d expected 18", se_cnt); else passes++;
        checks++; if (se_bad != 0) $display("FAIL good_se_phase: got %0d off-phase expected 0", se_bad); else passes++;
        checks++; if (wr_q.size() != 1) $display("FAIL good_writes: got %0d expected 1", wr_q.size()); else passes++;
        checks++; if (got !== 8'hA5) $display("FAIL good_data: got %h expected a5", got); else passes++;
        checks++; if ({r_error, rcving} !== 2'b00) $display("FAIL good_end_flags: got %b expected 00", {r_error, rcving}); else passes++;
    endtask

    task automatic test_bad_sync();
        logic [7:0] got;
        byte_q.delete(); byte_q.push_back(8'hA5);
        encode(8'h81);
        send_syms(1'b1);
        checks++; if (wr_q.size() != 0) $display("FAIL badsync_writes: got %0d expected 0", wr_q.size()); else passes++;
        checks++; if ({r_error, rcving} !== 2'b10) $display("FAIL badsync_flags: got %b expected 10", {r_error, rcving}); else passes++;
        for (int i = 0; i < 10; i++) step(-1, 1'b0, 1'b1, 1'b0);
        checks++; if (r_error !== 1'b1) $display("FAIL badsync_sticky: got %b expected 1", r_error); else passes++;
        byte_q.delete(); byte_q.push_back(8'h3C);
        encode(SYNC);
        send_syms(1'b1);
        got = (wr_q.size() > 0) ? wr_q[0] : 8'hxx;
        checks++; if (err_lead !== 1'b0) $display("FAIL badsync_clear_on_edge: got %b expected 0", err_lead); else passes++;
        checks++; if ((wr_q.size() != 1) || (got !== 8'h3C)) $display("FAIL badsync_next_packet: got %0d bytes first %h expected 1 bytes 3c", wr_q.size(), got); else passes++;
        checks++; if (r_error !== 1'b0) $display("FAIL badsync_next_err: got %b expected 0", r_error); else passes++;
    endtask

    task automatic test_stuffing();
        int   exp_n;
        logic exp_e;
        byte_q.delete(); byte_q.push_back(8'h00); byte_q.push_back(8'hFF);
        encode(SYNC);
        send_syms(1'b1);
        checks++;
        if ((wr_q.size() != 2) || (wr_q[0] !== 8'h00) || (wr_q[1] !== 8'hFF) || (r_error !== 1'b0))
            $display("FAIL stuff_zero: got %0d bytes last %h err %b expected 2 bytes 00 ff err 0",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 8'hxx, r_error);
        else passes++;
        sym_q[stuff_pos[0]] = 1;
`ifdef STUFF_CHECK_EN
        exp_n = 1; exp_e = 1'b1;
`else
        exp_n = 2; exp_e = 1'b0;
`endif
        send_syms(1'b1);
        checks++; if (wr_q.size() != exp_n) $display("FAIL stuff_one_writes: got %0d expected %0d", wr_q.size(), exp_n); else passes++;
        checks++; if (r_error !== exp_e) $display("FAIL stuff_one_err: got %b expected %b", r_error, exp_e); else passes++;
    endtask

    task automatic test_truncated();
        byte_q.delete(); byte_q.push_back(8'hA5);
        encode(SYNC);
        for (int i = 0; i < 4; i++) sym_q.delete(12);
        send_syms(1'b1);
        checks++; if (wr_q.size() != 0) $display("FAIL trunc_writes: got %0d expected 0", wr_q.size()); else passes++;
        checks++; if ({r_error, rcving} !== 2'b10) $display("FAIL trunc_flags: got %b expected 10", {r_error, rcving}); else passes++;
        checks++; if (se_cnt != 14) $display("FAIL trunc_se_count: got %0d expected 14", se_cnt); else passes++;
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] got;
        byte_q.delete(); byte_q.push_back(8'hA5);
        encode(SYNC);
        while (sym_q.size() > 13) void'(sym_q.pop_back());
        send_syms(1'b0);
        @(negedge clk); rst = 1'b1; d_edge = 1'b0; eop = 1'b0;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({rcving, w_enable, r_error, shift_enable} !== 4'b0000)
            $display("FAIL midrst_outputs: got %b expected 0000", {rcving, w_enable, r_error, shift_enable});
        else passes++;
        for (int i = 0; i < 8; i++) step(-1, 1'b0, 1'b1, 1'b0);
        byte_q.delete(); byte_q.push_back(8'h5A);
        encode(SYNC);
        send_syms(1'b1);
        got = (wr_q.size() > 0) ? wr_q[0] : 8'hxx;
        checks++;
        if ((wr_q.size() != 1) || (got !== 8'h5A) || (r_error !== 1'b0))
            $display("FAIL midrst_next_packet: got %0d bytes %h err %b expected 1 bytes 5a err 0", wr_q.size(), got, r_error);
        else passes++;
    endtask

    task automatic test_random();
        int nbytes, fault, k, j, bad;
        for (int n = 0; n < 12; n++) begin
            byte_q.delete();
            nbytes = $urandom_range(1, 3);
            for (int b = 0; b < nbytes; b++)
                byte_q.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
            encode(SYNC);
            fault = $urandom_range(0, 3);
            case (fault)
                1: begin
                    k = $urandom_range(1, 7);
                    for (int t = 0; t < k; t++) sym_q.delete(sym_q.size() - 3);
                end
                2: begin
                    j = $urandom_range(0, 7);
                    sym_q[j] = 1 - sym_q[j];
                end
                3: if (stuff_pos.size() > 0) sym_q[stuff_pos[0]] = 1;
                default: begin end
            endcase
            model();
            send_syms(1'b1);
            bad = 0;
            for (int b = 0; b < exp_q.size() && b < wr_q.size(); b++)
                if (wr_q[b] !== exp_q[b]) bad++;
            checks++;
            if ((wr_q.size() != exp_q.size()) || (bad != 0))
                $display("FAIL rand%0d_bytes: got %0d bytes (%0d differ) expected %0d bytes", n, wr_q.size(), bad, exp_q.size());
            else passes++;
            checks++;
            if (r_error !== exp_err) $display("FAIL rand%0d_err: got %b expected %b", n, r_error, exp_err); else passes++;
            checks++;
            if ((se_cnt != sym_q.size()) || (se_bad != 0))
                $display("FAIL rand%0d_strobe: got %0d pulses (%0d off-phase) expected %0d", n, se_cnt, se_bad, sym_q.size());
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_sync();
        test_stuffing();
        test_truncated();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
